systolic_input_feeder: RTL and testbench
========================================

Name: systolic_input_feeder

Overview:
- Upstream stage that feeds the left edge of the 2x2 systolic array.
- Buffers 2-element input vectors arriving over a valid/ready stream in a small FIFO.
- On command, emits a programmed number of vectors into the array and drives the array start strobe (sys_start).
- Applies the one-cycle diagonal skew so row-1 data reaches pe21 in the same cycle as the valid that pe11 forwards.

Parameters:
- DATA_W, 16, width of each activation element.
- FIFO_DEPTH, 4, number of buffered input vectors; power of two, at least 2.
- LEN_W, 16, width of the vector-count command field.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_row0  input  DATA_W  element destined for array row 0 (sys_data_in_11)
- in_row1  input  DATA_W  element destined for array row 1 (sys_data_in_21)
- in_valid  input  1  input vector valid
- in_ready  output  1  FIFO can accept; equals not-full
- cmd_valid  input  1  feed command valid
- cmd_len  input  LEN_W  number of vectors to feed
- cmd_ready  output  1  high only in IDLE
- sys_data_in_11  output  DATA_W  registered row-0 data to array
- sys_data_in_21  output  DATA_W  registered row-1 data to array, skewed +1 cycle
- sys_start  output  1  registered valid for row-0 data; drives array start
- busy  output  1  high in FEED or DRAIN
- done  output  1  one-cycle completion pulse
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, takes effect mid-operation too): FIFO emptied (fifo_count=0); state IDLE; all outputs registered low/zero (sys_data_in_11=0, sys_data_in_21=0, sys_start=0, done=0, busy=0). After reset, in_ready=1 and cmd_ready=1.
- Input push: occurs when in_valid && in_ready, in any state, so prefetch during IDLE is allowed. in_ready = (fifo_count != FIFO_DEPTH).
- Full FIFO: no push that cycle, even if a pop happens in the same cycle. in_ready is a pure function of registered occupancy, with no combinational path from the pop.
- Simultaneous push and pop when not full: occupancy unchanged. Data order is strictly FIFO.
- State IDLE: on cmd_valid && cmd_ready, latch remaining = cmd_len.
  - cmd_len != 0: go to FEED.
  - cmd_len == 0: go to DONE; no sys_start is ever asserted.
- State FEED, each cycle:
  - Pop when FIFO is non-empty (pop occurs only in FEED); pop decrements remaining. At the clock edge: sys_data_in_11 <= row0, sys_start <= 1, row1 held in skew register r1.
  - If FIFO is empty (bubble): sys_start <= 0, sys_data_in_11 <= 0, r1 <= 0.
  - Every cycle in FEED: sys_data_in_21 <= r1 (previous cycle's row1, or 0 after a bubble).
  - When the pop that brings remaining to 0 occurs, next state is DRAIN.
- State DRAIN, one cycle: sys_start <= 0, sys_data_in_11 <= 0, sys_data_in_21 <= r1 (last row1), r1 <= 0. Next state DONE.
- State DONE, one cycle: done=1; sys_data_in_21 <= 0. Next state IDLE.
- Latency and alignment:
  - A vector popped in cycle t appears on sys_data_in_11 with sys_start=1 in cycle t+1, and on sys_data_in_21 in cycle t+2.
  - A gap-free burst of N vectors produces N consecutive sys_start cycles.
- busy = state in {FEED, DRAIN}. cmd_valid outside IDLE is ignored (cmd_ready=0).
- remaining is LEN_W bits with no wrap: it only decrements on a pop and FEED exits at 0.
- cmd_len of 2^LEN_W-1 is legal.

Test Plan:
1. Reset then idle.
   - Stimulus: rst pulse, no traffic.
   - Required: all outputs 0, in_ready=1, cmd_ready=1, fifo_count=0.
2. Prefetch then feed.
   - Stimulus: push (1,2),(3,4),(5,6) in IDLE, then cmd_len=3.
   - Required: sys_start high for 3 consecutive cycles with sys_data_in_11 = 1,3,5. sys_data_in_21 = 2,4,6, each one cycle later. done pulses exactly once, 2 cycles after the last sys_start; busy low after done.
3. Underflow bubble.
   - Stimulus: cmd_len=2 with FIFO empty; push (7,8), wait 3 cycles, push (9,10).
   - Required: sys_start pulses for 7 and for 9, separated by bubble cycles with data 0. sys_data_in_21 shows 8 then 10, each one cycle after its row0.
4. Full FIFO backpressure.
   - Stimulus: hold in_valid with values 1..6, no command.
   - Required: exactly 4 accepted, in_ready=0 at fifo_count=4. A subsequent cmd_len=4 emits 1..4 in order; in_ready stays 0 until the first pop.
5. Zero length and busy command.
   - cmd_len=0: done pulses 2 cycles after the handshake, no sys_start, FIFO untouched.
   - cmd_valid held during FEED: not accepted until IDLE.
6. Reset mid-feed.
   - Stimulus: assert rst during FEED of cmd_len=4 after 2 pops.
   - Required: immediate zero outputs, fifo_count=0, state IDLE, no done pulse.

Source files
------------

// File: rtl/systolic_input_feeder_if.sv
// Stream, command and array-edge signals of the systolic input feeder.
// master = upstream/array side, slave = the feeder itself.
interface systolic_input_feeder_if #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] in_row0;
    logic [DATA_W-1:0] in_row1;
    logic              in_valid;
    logic              in_ready;
    logic              cmd_valid;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_ready;
    logic [DATA_W-1:0] sys_data_in_11;
    logic [DATA_W-1:0] sys_data_in_21;
    logic              sys_start;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output in_row0, in_row1, in_valid, cmd_valid, cmd_len,
        input  in_ready, cmd_ready, sys_data_in_11, sys_data_in_21,
               sys_start, busy, done, fifo_count
    );

    modport slave (
        input  in_row0, in_row1, in_valid, cmd_valid, cmd_len,
        output in_ready, cmd_ready, sys_data_in_11, sys_data_in_21,
               sys_start, busy, done, fifo_count
    );
endinterface

// File: rtl/systolic_input_feeder.sv
// Buffers 2-element activation vectors and feeds a commanded number of them
// into the left edge of a 2x2 systolic array, skewing row 1 by one cycle.
module systolic_input_feeder #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    systolic_input_feeder_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [LEN_W-1:0]       remaining_reg, remaining_next;
    logic [DATA_W-1:0]      d11_reg, d11_next;
    logic [DATA_W-1:0]      d21_reg, d21_next;
    logic [DATA_W-1:0]      r1_reg, r1_next;
    logic                   start_reg, start_next;
    logic                   done_reg, done_next;

    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   full, empty, push, pop;
    logic [1:0][DATA_W-1:0] in_lane;
    logic [1:0][DATA_W-1:0] head;

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign push    = bus.in_valid && !full;
    assign pop     = (state_reg == FEED) && !empty;
    assign in_lane = {bus.in_row1, bus.in_row0};

    // One storage lane per array row; head is read straight into the output registers.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [DATA_W-1:0] mem [FIFO_DEPTH];

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr_reg] <= in_lane[gi];
            end
        end

        assign head[gi] = mem[rd_ptr_reg];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            d11_reg       <= '0;
            d21_reg       <= '0;
            r1_reg        <= '0;
            start_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            d11_reg       <= d11_next;
            d21_reg       <= d21_next;
            r1_reg        <= r1_next;
            start_reg     <= start_next;
            done_reg      <= done_next;
        end
    end

    // Outputs default to zero; FEED/DRAIN override them with popped or skewed data.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        d11_next       = '0;
        d21_next       = '0;
        r1_next        = '0;
        start_next     = 1'b0;
        done_next      = (state_reg == DONE);
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    remaining_next = bus.cmd_len;
                    state_next     = (bus.cmd_len == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                d21_next = r1_reg;
                if (pop) begin
                    d11_next       = head[0];
                    r1_next        = head[1];
                    start_next     = 1'b1;
                    remaining_next = remaining_reg - LEN_W'(1);
                    if (remaining_reg == LEN_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                d21_next   = r1_reg;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready       = !full;
    assign bus.cmd_ready      = (state_reg == IDLE);
    assign bus.busy           = (state_reg == FEED) || (state_reg == DRAIN);
    assign bus.done           = done_reg;
    assign bus.sys_start      = start_reg;
    assign bus.sys_data_in_11 = d11_reg;
    assign bus.sys_data_in_21 = d21_reg;
    assign bus.fifo_count     = count_reg;
endmodule

// File: tb/tb_systolic_input_feeder.sv
// Randomized and directed bench for systolic_input_feeder, checked every cycle
// against a queue model built from the pop/latency rules of the feeder.
module tb_systolic_input_feeder;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] r0;
        logic [15:0] r1;
    } vec_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    systolic_input_feeder_if #(.DATA_W(16), .FIFO_DEPTH(DEPTH), .LEN_W(16)) bus ();

    systolic_input_feeder #(.DATA_W(16), .FIFO_DEPTH(DEPTH), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO contents plus expected outputs scheduled by cycle.
    vec_t        mq[$];
    int          cyc;
    int          feed_left;
    int          drain_cyc;
    int          done_cyc;
    int          ready_cyc;
    logic        st_ring [8];
    logic [15:0] e11_ring [8];
    logic [15:0] e21_ring [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        feed_left = 0;
        drain_cyc = -10;
        done_cyc  = -10;
        ready_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            st_ring[i]  = 1'b0;
            e11_ring[i] = '0;
            e21_ring[i] = '0;
        end
    endtask

    task automatic check_all();
        int s;
        s = cyc % 8;
        check_eq("sys_start",  32'(bus.sys_start),      32'(st_ring[s]));
        check_eq("data_11",    32'(bus.sys_data_in_11), 32'(e11_ring[s]));
        check_eq("data_21",    32'(bus.sys_data_in_21), 32'(e21_ring[s]));
        check_eq("busy",       32'(bus.busy),           32'(feed_left > 0 || cyc == drain_cyc));
        check_eq("done",       32'(bus.done),           32'(cyc == done_cyc));
        check_eq("cmd_ready",  32'(bus.cmd_ready),      32'(feed_left == 0 && cyc >= ready_cyc));
        check_eq("in_ready",   32'(bus.in_ready),       32'(mq.size() != DEPTH));
        check_eq("fifo_count", 32'(bus.fifo_count),     32'(mq.size()));
        st_ring[s]  = 1'b0;
        e11_ring[s] = '0;
        e21_ring[s] = '0;
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input bit iv, input logic [15:0] a, input logic [15:0] b,
                        input bit cv, input logic [15:0] len);
        bit   cmd_ok;
        bit   push_ok;
        vec_t v;
        bus.in_valid  = iv;
        bus.in_row0   = a;
        bus.in_row1   = b;
        bus.cmd_valid = cv;
        bus.cmd_len   = len;
        cmd_ok  = (feed_left == 0) && (cyc >= ready_cyc);
        push_ok = iv && (mq.size() != DEPTH);
        if (feed_left > 0 && mq.size() > 0) begin
            v = mq.pop_front();
            st_ring[(cyc + 1) % 8]  = 1'b1;
            e11_ring[(cyc + 1) % 8] = v.r0;
            e21_ring[(cyc + 2) % 8] = v.r1;
            feed_left--;
            if (feed_left == 0) begin
                drain_cyc = cyc + 1;
                done_cyc  = cyc + 3;
                ready_cyc = cyc + 3;
            end
        end
        if (push_ok) begin
            v.r0 = a;
            v.r1 = b;
            mq.push_back(v);
        end
        if (cv && cmd_ok) begin
            $display("cmd accepted len=%0d cycle=%0d fifo=%0d", len, cyc, mq.size());
            if (len == 0) begin
                done_cyc  = cyc + 2;
                ready_cyc = cyc + 2;
            end else begin
                feed_left = int'(len);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 16'd0);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_clear();
        check_all();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
        rst = 1'b0;
        $display("reset applied cycle=%0d", cyc);
    endtask

    initial begin
        cyc           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_row0   = '0;
        bus.in_row1   = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        idle(2);

        // Prefetch three vectors, then feed them
        step(1'b1, 16'd1, 16'd2, 1'b0, 16'd0);
        step(1'b1, 16'd3, 16'd4, 1'b0, 16'd0);
        step(1'b1, 16'd5, 16'd6, 1'b0, 16'd0);
        step(1'b0, 16'd0, 16'd0, 1'b1, 16'd3);
        idle(7);

        // Underflow bubbles between late-arriving vectors
        step(1'b0, 16'd0, 16'd0, 1'b1, 16'd2);
        step(1'b1, 16'd7, 16'd8, 1'b0, 16'd0);
        idle(3);
        step(1'b1, 16'd9, 16'd10, 1'b0, 16'd0);
        idle(6);

        // Backpressure: offer 1..6 with no command, then drain four
        for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 16'(i + 100), 1'b0, 16'd0);
        step(1'b1, 16'd77, 16'd78, 1'b1, 16'd4);
        idle(8);

        // Zero-length command with data buffered, then a held command during FEED
        step(1'b1, 16'd11, 16'd12, 1'b0, 16'd0);
        step(1'b0, 16'd0, 16'd0, 1'b1, 16'd0);
        idle(3);
        for (int i = 0; i < 10; i++) step(1'b1, 16'(20 + i), 16'(40 + i), 1'b1, 16'd2);
        idle(8);

        // Reset in the middle of a four-vector feed
        for (int i = 0; i < 4; i++) step(1'b1, 16'(60 + i), 16'(80 + i), 1'b0, 16'd0);
        step(1'b0, 16'd0, 16'd0, 1'b1, 16'd4);
        idle(2);
        do_reset();
        idle(4);

        // Random traffic, with one asynchronous reset along the way
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step($urandom_range(0, 99) < 55, 16'($urandom), 16'($urandom),
                 $urandom_range(0, 99) < 12, 16'($urandom_range(0, 6)));
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
